// File: rtl/anf_pkg.sv
// Shared widths, FSM state type and mask bit-placement helper for the ANF mask generator.
// Optional feature macro used by the block: ANF_BIJ_CHECK_EN.
package anf_pkg;

    localparam int ANF_NIB_W   = 4;
    localparam int ANF_ENTRIES = 16;
    localparam int ANF_MASK_W  = 64;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_XFORM = 2'd1,
        ST_DONE  = 2'd2
    } anf_state_t;

    // Bit position of monomial k for output bit j: 16*j + 15 - k.
    function automatic logic [5:0] anf_mask_idx(input logic [1:0] j, input logic [3:0] k);
        return {j, 4'hF - k};
    endfunction

endpackage

// File: rtl/anf_mask_gen_if.sv
// Streaming interface of the ANF mask generator: truth-table entries in, 64-bit mask out.
// out_bij exists only when ANF_BIJ_CHECK_EN is defined.
interface anf_mask_gen_if;
    import anf_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [ANF_NIB_W-1:0]  in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ANF_MASK_W-1:0] out_mask;
`ifdef ANF_BIJ_CHECK_EN
    logic                  out_bij;
`endif

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_mask
`ifdef ANF_BIJ_CHECK_EN
        , output out_bij
`endif
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_mask
`ifdef ANF_BIJ_CHECK_EN
        , input out_bij
`endif
    );

endinterface

// File: rtl/anf_moebius_stage.sv
// One butterfly stage of the binary Moebius transform over 16 nibble coefficients.
// Entry x lives at arr[4x+3:4x]; all four output bits are transformed together.
module anf_moebius_stage
    import anf_pkg::*;
(
    input  logic [ANF_MASK_W-1:0] arr_in,
    input  logic [1:0]            stage,
    output logic [ANF_MASK_W-1:0] arr_out
);

    logic [3:0] k_idx;
    logic [3:0] partner;

    always_comb begin
        arr_out = arr_in;
        k_idx   = '0;
        partner = '0;
        for (int k = 0; k < ANF_ENTRIES; k++) begin
            k_idx = 4'(k);
            if (k_idx[stage]) begin
                partner = k_idx ^ (4'b0001 << stage);
                arr_out[{k_idx, 2'b00} +: 4] = arr_in[{k_idx, 2'b00} +: 4]
                                             ^ arr_in[{partner, 2'b00} +: 4];
            end
        end
    end

endmodule

// File: rtl/anf_mask_gen.sv
// Converts a streamed 16x4 S-box truth table into the 64-bit ANF mask of the nonlinear unit.
// Define ANF_BIJ_CHECK_EN to add the permutation flag out_bij.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_LOAD  | accepting entries f(0)..f(15) into the coefficient array
// ST_XFORM | one Moebius stage per cycle, stages 0..3
// ST_DONE  | mask presented, waiting for out_ready
module anf_mask_gen
    import anf_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    anf_mask_gen_if.slave  bus
);

    anf_state_t            state;
    anf_state_t            state_next;
    logic [3:0]            idx;
    logic [1:0]            stage;
    logic [ANF_MASK_W-1:0] arr;
    logic [ANF_MASK_W-1:0] arr_stage;
    logic [ANF_MASK_W-1:0] mask_c;
    logic [5:0]            src_pos;
    logic                  accept;
    logic                  last_accept;

    assign accept      = (state == ST_LOAD) && bus.in_valid;
    assign last_accept = accept && (idx == 4'hF);

    anf_moebius_stage u_stage (
        .arr_in  (arr),
        .stage   (stage),
        .arr_out (arr_stage)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD:  if (last_accept)      state_next = ST_XFORM;
                ST_XFORM: if (stage == 2'd3)    state_next = ST_DONE;
                ST_DONE:  if (bus.out_ready)    state_next = ST_LOAD;
                default:                        state_next = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            stage <= '0;
            arr   <= '0;
        end else if (clr) begin
            idx   <= '0;
            stage <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        arr[{idx, 2'b00} +: 4] <= bus.in_data;
                        idx                    <= idx + 4'd1;
                        stage                  <= '0;
                    end
                end
                ST_XFORM: begin
                    arr   <= arr_stage;
                    stage <= stage + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // The array is already the coefficient set once in DONE; this is pure rewiring.
    always_comb begin
        mask_c  = '0;
        src_pos = '0;
        if (state == ST_DONE) begin
            for (int k = 0; k < ANF_ENTRIES; k++) begin
                for (int j = 0; j < ANF_NIB_W; j++) begin
                    src_pos = 6'(4 * k + j);
                    mask_c[anf_mask_idx(2'(j), 4'(k))] = arr[src_pos];
                end
            end
        end
    end

    assign bus.in_ready  = (state == ST_LOAD);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_mask  = mask_c;

`ifdef ANF_BIJ_CHECK_EN
    logic [ANF_ENTRIES-1:0] seen;
    logic [ANF_ENTRIES-1:0] seen_hit;
    logic                   bij_q;

    assign seen_hit = seen | (16'h0001 << bus.in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen  <= '0;
            bij_q <= 1'b0;
        end else if (clr) begin
            seen  <= '0;
            bij_q <= 1'b0;
        end else if (accept) begin
            if (last_accept) begin
                bij_q <= &seen_hit;
                seen  <= '0;
            end else begin
                seen  <= seen_hit;
            end
        end
    end

    assign bus.out_bij = bij_q;
`endif

endmodule

// File: tb/tb_anf_mask_gen.sv
// Randomized self-checking bench for anf_mask_gen against a subset-sum ANF reference model.
// Bijectivity checks are compiled in only when ANF_BIJ_CHECK_EN is defined.
module tb_anf_mask_gen;
    import anf_pkg::*;

    logic clk;
    logic rst_n;
    logic clr;

    anf_mask_gen_if bus_if ();

    anf_mask_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks;
    int         n_fail;
    logic [3:0] tbl [16];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Coefficient of monomial k = XOR of f(x) over all x whose bits are a subset of k.
    function automatic logic [63:0] ref_mask();
        logic [63:0] m;
        logic        c;
        m = '0;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 16; k++) begin
                c = 1'b0;
                for (int x = 0; x < 16; x++)
                    if ((x & ~k & 15) == 0) c ^= tbl[x][j];
                m[16 * j + 15 - k] = c;
            end
        end
        return m;
    endfunction

    function automatic logic ref_bij();
        int cnt [16];
        for (int v = 0; v < 16; v++) cnt[v] = 0;
        for (int x = 0; x < 16; x++) cnt[tbl[x]]++;
        for (int v = 0; v < 16; v++) if (cnt[v] != 1) return 1'b0;
        return 1'b1;
    endfunction

    // Evaluate the ANF S-box described by mask m at input x.
    function automatic logic [3:0] eval_sbox(input logic [63:0] m, input int x);
        logic [3:0] r;
        r = '0;
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 16; k++)
                if ((k & ~x & 15) == 0) r[j] ^= m[16 * j + 15 - k];
        return r;
    endfunction

    // Streams tbl[0..n-1], dropping in_valid with probability gap_pct.
    task automatic load_tbl(input int gap_pct, input int n, output bit ok);
        int tries;
        bit done;
        ok = 1'b1;
        for (int x = 0; x < n; x++) begin
            tries = 0;
            done  = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (int'($urandom_range(99)) < gap_pct) begin
                    bus_if.in_valid = 1'b0;
                    bus_if.in_data  = 4'($urandom);
                end else begin
                    bus_if.in_valid = 1'b1;
                    bus_if.in_data  = tbl[x];
                end
                done = bus_if.in_valid && bus_if.in_ready;
                @(posedge clk);
                tries++;
                if (!done && tries > 200) begin
                    check_val("load_timeout", 64'(x), 64'(n));
                    #1 bus_if.in_valid = 1'b0;
                    ok = 1'b0;
                    return;
                end
            end
        end
        #1 bus_if.in_valid = 1'b0;
    endtask

    task automatic run_case(input string tag, input int gap_pct, input int hold,
                            input logic [63:0] exp_mask, input logic exp_bij);
        bit          ok;
        logic [63:0] mask;
        logic [63:0] got_t;
        logic [63:0] exp_t;
        load_tbl(gap_pct, 16, ok);
        if (!ok) return;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            check_val({tag, "_lat_valid"}, 64'(bus_if.out_valid), 64'(c == 4));
            if (c < 4) check_val({tag, "_xform_mask0"}, bus_if.out_mask, 64'h0);
        end
        mask = bus_if.out_mask;
        check_val({tag, "_mask"}, mask, exp_mask);
        got_t = '0;
        exp_t = '0;
        for (int x = 0; x < 16; x++) begin
            got_t[4 * x +: 4] = eval_sbox(mask, x);
            exp_t[4 * x +: 4] = tbl[x];
        end
        check_val({tag, "_sbox"}, got_t, exp_t);
`ifdef ANF_BIJ_CHECK_EN
        check_val({tag, "_bij"}, 64'(bus_if.out_bij), 64'(exp_bij));
`else
        if (exp_bij === 1'bx) $display("note: bij unknown for %s", tag);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus_if.in_valid  = 1'b1;
            bus_if.in_data   = 4'($urandom);
            bus_if.out_ready = 1'b0;
            @(posedge clk);
            #1;
            check_val({tag, "_hold_valid"}, 64'(bus_if.out_valid), 64'h1);
            check_val({tag, "_hold_mask"}, bus_if.out_mask, mask);
            check_val({tag, "_hold_ready"}, 64'(bus_if.in_ready), 64'h0);
        end
        @(negedge clk);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        check_val({tag, "_post_valid"}, 64'(bus_if.out_valid), 64'h0);
        check_val({tag, "_post_ready"}, 64'(bus_if.in_ready), 64'h1);
        check_val({tag, "_post_mask"}, bus_if.out_mask, 64'h0);
    endtask

    task automatic set_identity();
        for (int x = 0; x < 16; x++) tbl[x] = 4'(x);
    endtask

    task automatic set_random();
        for (int x = 0; x < 16; x++) tbl[x] = 4'($urandom);
    endtask

    task automatic set_perm();
        int         j;
        logic [3:0] t;
        set_identity();
        for (int i = 15; i > 0; i--) begin
            j      = int'($urandom_range(i));
            t      = tbl[i];
            tbl[i] = tbl[j];
            tbl[j] = t;
        end
    endtask

    localparam logic [63:0] M_IDENT = 64'h0080_0800_2000_4000;

    initial begin
        bit ok;
        n_checks         = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        clr              = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(bus_if.out_valid), 64'h0);
        check_val("rst_mask", bus_if.out_mask, 64'h0);
`ifdef ANF_BIJ_CHECK_EN
        check_val("rst_bij", 64'(bus_if.out_bij), 64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_ready", 64'(bus_if.in_ready), 64'h1);

        set_identity();
        run_case("ident", 0, 0, M_IDENT, 1'b1);
        for (int x = 0; x < 16; x++) tbl[x] = 4'hF;
        run_case("constf", 30, 3, 64'h8000_8000_8000_8000, 1'b0);
        for (int x = 0; x < 16; x++) tbl[x] = 4'h0;
        run_case("zero", 0, 1, 64'h0, 1'b0);
        for (int x = 0; x < 16; x++) tbl[x] = 4'(x) ^ 4'hF;
        run_case("compl", 50, 3, 64'h8080_8800_A000_C000, 1'b1);
        set_identity();
        run_case("ident_gap", 60, 2, M_IDENT, 1'b1);

        for (int r = 0; r < 10; r++) begin
            set_random();
            run_case("rand", int'($urandom_range(50)), int'($urandom_range(3)), ref_mask(), ref_bij());
        end
        for (int r = 0; r < 4; r++) begin
            set_perm();
            run_case("perm", int'($urandom_range(40)), int'($urandom_range(3)), ref_mask(), ref_bij());
        end

        // Abort a partial load after 7 entries, then a clean identity load.
        set_random();
        load_tbl(20, 7, ok);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_val("clr_load_ready", 64'(bus_if.in_ready), 64'h1);
        set_identity();
        run_case("clr_ident", 0, 0, M_IDENT, 1'b1);

        // clr wins over an out handshake in DONE.
        set_random();
        load_tbl(0, 16, ok);
        repeat (4) @(posedge clk);
        #1;
        check_val("clr_done_valid_pre", 64'(bus_if.out_valid), 64'h1);
        @(negedge clk);
        clr              = 1'b1;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr              = 1'b0;
        bus_if.out_ready = 1'b0;
        check_val("clr_done_valid", 64'(bus_if.out_valid), 64'h0);
        check_val("clr_done_ready", 64'(bus_if.in_ready), 64'h1);
        check_val("clr_done_mask", bus_if.out_mask, 64'h0);

        // clr mid-transform must not let a mask escape later.
        set_random();
        load_tbl(0, 16, ok);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_val("clr_xform_valid", 64'(bus_if.out_valid), 64'h0);
            @(posedge clk);
            #1;
        end
        for (int x = 0; x < 16; x++) tbl[x] = 4'(x) ^ 4'hF;
        run_case("clr_compl", 10, 1, 64'h8080_8800_A000_C000, 1'b1);

        // Reset pulse during XFORM.
        set_random();
        load_tbl(0, 16, ok);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rstx_valid", 64'(bus_if.out_valid), 64'h0);
        check_val("rstx_mask", bus_if.out_mask, 64'h0);
        check_val("rstx_ready", 64'(bus_if.in_ready), 64'h1);
`ifdef ANF_BIJ_CHECK_EN
        check_val("rstx_bij", 64'(bus_if.out_bij), 64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_val("rstx_no_stale", 64'(bus_if.out_valid), 64'h0);
        end
        set_identity();
        run_case("rst_ident", 0, 0, M_IDENT, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
